// File: rtl/regfile_32x32_onehot_wr.sv
// 32 x DATA_W register file: two combinational read ports, one write port strobed directly
// by a one-hot select. r0 reads as zero; malformed selects are dropped and flagged.
module regfile_32x32_onehot_wr #(
    parameter int unsigned DATA_W = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [4:0]        Ard1,
    input  logic [4:0]        Ard2,
    input  logic [31:0]       WrSel,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2,
    output logic              SelErr
);

    logic              sel_onehot;
    logic              wr_commit;
    logic              wr_reject;
    logic              sel_err_q;
    logic [DATA_W-1:0] regs_q [1:31];
    logic [DATA_W-1:0] rd_val [32];

    // x & (x - 1) clears the lowest set bit; zero result means at most one bit was set
    assign sel_onehot = (WrSel != 32'd0) && ((WrSel & (WrSel - 32'd1)) == 32'd0);
    assign wr_commit  = WrEn && sel_onehot && !Rst;
    assign wr_reject  = WrEn && !sel_onehot;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        always_ff @(posedge Clk) begin
            if (Rst) begin
                regs_q[i] <= '0;
            end else if (wr_commit && WrSel[i]) begin
                regs_q[i] <= Din;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= wr_reject;
        end
    end

    // Bypass is gated by wr_commit, so it is naturally suppressed during reset
    always_comb begin
        rd_val[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rd_val[i] = (BYPASS && wr_commit && WrSel[i]) ? Din : regs_q[i];
        end
    end

    assign Dout1  = rd_val[Ard1];
    assign Dout2  = rd_val[Ard2];
    assign SelErr = sel_err_q;

endmodule

// File: tb/tb_regfile_32x32_onehot_wr.sv
// Scoreboard bench: driver pushes expected outputs for both BYPASS variants, a monitor on
// the falling edge pops and compares.
module tb_regfile_32x32_onehot_wr;

    logic        clk;
    logic        rst;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic [31:0] wr_sel;
    logic        wr_en;
    logic [31:0] din;
    logic [31:0] dout1_b, dout2_b, dout1_n, dout2_n;
    logic        sel_err_b, sel_err_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] d1_b;
        logic [31:0] d2_b;
        logic [31:0] d1_n;
        logic [31:0] d2_n;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    logic        err_model;

    regfile_32x32_onehot_wr #(.DATA_W(32), .BYPASS(1'b1)) dut_byp (
        .Clk(clk), .Rst(rst), .Ard1(ard1), .Ard2(ard2), .WrSel(wr_sel), .WrEn(wr_en),
        .Din(din), .Dout1(dout1_b), .Dout2(dout2_b), .SelErr(sel_err_b)
    );

    regfile_32x32_onehot_wr #(.DATA_W(32), .BYPASS(1'b0)) dut_nob (
        .Clk(clk), .Rst(rst), .Ard1(ard1), .Ard2(ard2), .WrSel(wr_sel), .WrEn(wr_en),
        .Din(din), .Dout1(dout1_n), .Dout2(dout2_n), .SelErr(sel_err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && !rst && wr_en && $countones(wr_sel) == 1 && wr_sel[a]) return din;
        return model[a];
    endfunction

    // Drive one cycle, push expectations, then apply the architectural effect of the edge
    task automatic cycle(input string tag, input logic r, input logic we, input logic [31:0] sel,
                         input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rst = r; wr_en = we; wr_sel = sel; din = d; ard1 = a1; ard2 = a2;
        e.tag  = tag;
        e.d1_b = exp_read(a1, 1'b1);
        e.d2_b = exp_read(a2, 1'b1);
        e.d1_n = exp_read(a1, 1'b0);
        e.d2_n = exp_read(a2, 1'b0);
        e.err  = err_model;
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            foreach (model[i]) model[i] = 32'd0;
            err_model = 1'b0;
        end else begin
            err_model = we && ($countones(sel) != 1);
            if (we && $countones(sel) == 1) begin
                for (int i = 1; i < 32; i++) if (sel[i]) model[i] = d;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, " dout1 byp"}, dout1_b, e.d1_b);
            check({e.tag, " dout2 byp"}, dout2_b, e.d2_b);
            check({e.tag, " dout1 nobyp"}, dout1_n, e.d1_n);
            check({e.tag, " dout2 nobyp"}, dout2_n, e.d2_n);
            check({e.tag, " selerr byp"}, {31'd0, sel_err_b}, {31'd0, e.err});
            check({e.tag, " selerr nobyp"}, {31'd0, sel_err_n}, {31'd0, e.err});
        end
    end

    initial begin
        logic [31:0] sel;
        logic [4:0]  a;
        // Unscored initial reset: storage is unknown before the first edge
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; din = '0; ard1 = '0; ard2 = '0;
        foreach (model[i]) model[i] = 32'd0;
        err_model = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) cycle("reset_read", 1'b0, 1'b0, 32'd0, 32'd0, 5'(i), 5'(31 - i));

        cycle("wr_r5", 1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd5);
        cycle("rd_r5", 1'b0, 1'b0, 32'd0, 32'd0, 5'd5, 5'd5);
        cycle("rd_r4_r6", 1'b0, 1'b0, 32'd0, 32'd0, 5'd4, 5'd6);

        cycle("wr_r0", 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cycle("rd_r0", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5);

        cycle("bad_two", 1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, 5'd4, 5'd5);
        cycle("bad_zero", 1'b0, 1'b1, 32'h0000_0000, 32'h2222_2222, 5'd4, 5'd5);
        cycle("after_bad", 1'b0, 1'b0, 32'h0000_0030, 32'd0, 5'd4, 5'd5);
        cycle("idle_noerr", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd4, 5'd5);

        cycle("wr_r31", 1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, 5'd30, 5'd31);
        cycle("rd_r31", 1'b0, 1'b0, 32'd0, 32'd0, 5'd31, 5'd31);

        for (int i = 1; i < 32; i++) begin
            sel = 32'd1 << i;
            cycle("fill", 1'b0, 1'b1, sel, 32'(i), 5'(i - 1), 5'(i));
        end
        for (int i = 0; i < 32; i++) cycle("fill_read", 1'b0, 1'b0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
        cycle("rst_wr_r7", 1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 5'd7, 5'd7);
        for (int i = 0; i < 32; i++) cycle("post_rst", 1'b0, 1'b0, 32'd0, 32'd0, 5'(i), 5'(i));

        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(9))
                0:       sel = 32'd0;
                1:       sel = $urandom;
                2:       sel = (32'd1 << $urandom_range(31)) | (32'd1 << $urandom_range(31));
                default: sel = 32'd1 << $urandom_range(31);
            endcase
            a = 5'($urandom_range(31));
            cycle("random", ($urandom_range(49) == 0), ($urandom_range(3) != 0), sel, $urandom,
                  ($urandom_range(2) == 0) ? a : 5'($urandom_range(31)), a);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
